ip_sound_mixer: RTL and testbench
=================================

Name: ip_sound_mixer

Overview:
- Upstream stage of the PWM DAC. Mixes four signed 16-bit sound sources (PSG, SCC, OPLL, aux), each with its own 4-bit volume.
- Uses a time-multiplexed multiply-accumulate: one channel per clock after each sample tick.
- Saturates the sum to the 17-bit signed `signal_level` format the PWM integrator expects.
- Also generates the PWM's periodic `enable` strobe.

Parameters:
- PWM_DIV, 1: period of the pwm_enable strobe in clk cycles. Legal range 1..65535; 1 means pwm_enable is held high.
- NUM_CH, 4: number of input channels. Fixed at 4; changing it is not supported.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- n_reset  input  1  asynchronous active-low reset; release is synchronised externally.
- sample_tick  input  1  one-clock strobe that starts a mix cycle.
- ch0_in..ch3_in  input  16 each  signed two's-complement channel samples.
- ch0_vol..ch3_vol  input  4 each  unsigned channel gain, 0..15 (0 = silent).
- mute  input  1  when high at the DONE state, the result is forced to 0.
- signal_level  output  17  signed, saturated mix result; feeds the PWM signal_level input.
- level_valid  output  1  one-clock pulse when signal_level updates.
- overrun  output  1  one-clock pulse when a sample_tick is dropped.
- pwm_enable  output  1  periodic strobe; feeds the PWM enable input.

Behaviour:
- Reset values (async, immediate): signal_level=0, level_valid=0, overrun=0, pwm_enable=0, state=IDLE, acc=0, idx=0, divider counter=0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - sample_tick=1 at edge k: capture all ch*_in and ch*_vol into holding registers.
  - Set acc=0, idx=0, state→ACC.
- ACC (edges k+1..k+4):
  - acc += sext(sample[idx]) * vol[idx], using the captured values only.
  - idx increments each cycle; after the idx=3 add, state→DONE.
- DONE (edge k+5):
  - result = acc >>> 2, arithmetic shift.
  - Clamp result to [-65536, 65535].
  - signal_level ← mute ? 0 : clamped value.
  - level_valid=1 for exactly that one cycle; state→IDLE.
- Latency: tick at edge k gives the new signal_level visible after edge k+5. Minimum accepted tick spacing is 6 clocks.
- Width rules:
  - Each product: 16b signed × 5b zero-extended volume = 20b signed.
  - Accumulator: 22b signed, which cannot overflow for 4 channels.
  - Shift result: 20b, then saturated to 17b.
- sample_tick while in ACC or DONE: the tick is ignored, overrun pulses high for 1 cycle, and the current mix completes unaffected.
- Input changes after the capture edge have no effect on the mix in progress.
- Reset asserted mid-ACC: the mix is aborted, no level_valid is produced, and outputs return to reset values.
- pwm_enable divider:
  - Counter runs 0..PWM_DIV-1, free-running from reset release and independent of the FSM.
  - pwm_enable=1 in the cycle the counter equals PWM_DIV-1.
  - PWM_DIV=1: pwm_enable is high every cycle after the first post-reset edge.
- signal_level holds its value between mixes, so the PWM integrates the last value.

Decomposition:
- Shared package ip_sound_pkg:
  - Widths: SAMPLE_W=16, VOL_W=4, ACC_W=22, LEVEL_W=17.
  - LEVEL_MAX=65535 and LEVEL_MIN=-65536.
  - FSM state encoding constants.
- One sub-module, ip_pwm_enable_gen: the PWM_DIV counter/strobe, parameterised by PWM_DIV.
- The mixer FSM and MAC stay in ip_sound_mixer.

Test Plan:
- Nominal mix: all vol=8; ch=1000, 2000, -500, 0; tick at edge k → signal_level=5000 after edge k+5, level_valid high one cycle, overrun=0.
- Positive saturation: all ch=32767, vol=15 → raw 491505, signal_level=65535. Negative saturation: all ch=-32768, vol=15 → signal_level=-65536.
- Overrun: ticks at k and k+3 → overrun pulse after edge k+3, a single level_valid after k+5, result from the k-captured inputs. A tick at k+6 is accepted normally.
- Mute and hold: vol=15, ch0=4000, others 0, mute=1 → signal_level=0. Next mix with mute=0 → 15000. Between ticks signal_level is held, and changing ch*_in mid-ACC does not alter the result.
- Reset mid-op: assert n_reset at k+2 (asynchronous, between edges) → signal_level=0 immediately, no level_valid. After release, a fresh tick mixes correctly.
- Divider: PWM_DIV=4 → pwm_enable pattern 0,0,0,1 repeating from reset release. PWM_DIV=1 → constant 1.

Source files
------------

// File: rtl/ip_sound_pkg.sv
// Shared widths, limits and FSM encoding for the sound mixer slice.
// Also holds the 17-bit level saturation helper.
package ip_sound_pkg;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned VOL_W     = 4;
  localparam int unsigned PROD_W    = SAMPLE_W + VOL_W;
  localparam int unsigned ACC_W     = 22;
  localparam int unsigned SHIFT_W   = 20;
  localparam int unsigned LEVEL_W   = 17;
  localparam int unsigned PWM_CNT_W = 16;

  localparam int LEVEL_MAX = 65535;
  localparam int LEVEL_MIN = -65536;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } mix_state_t;

  function automatic logic signed [LEVEL_W-1:0] sat_level(input logic signed [SHIFT_W-1:0] v);
    if (int'(v) > LEVEL_MAX) begin
      return LEVEL_W'(LEVEL_MAX);
    end else if (int'(v) < LEVEL_MIN) begin
      return LEVEL_W'(LEVEL_MIN);
    end else begin
      return LEVEL_W'(v);
    end
  endfunction

endpackage

// File: rtl/ip_sound_mixer_pwm_enable_gen.sv
// Free-running divider producing the periodic PWM enable strobe.
// The strobe is registered so it reads 0 while reset is held.
module ip_pwm_enable_gen
  import ip_sound_pkg::*;
#(
  parameter int unsigned PWM_DIV = 1
) (
  input  logic clk,
  input  logic n_reset,
  output logic pwm_enable
);

  localparam logic [PWM_CNT_W-1:0] CNT_LAST = PWM_CNT_W'(PWM_DIV - 1);

  logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 en_q, en_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + PWM_CNT_W'(1);
    en_d  = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign pwm_enable = en_q;

endmodule

// File: rtl/ip_sound_mixer.sv
// Four-channel volume mixer: one MAC per clock after a sample tick,
// then arithmetic shift, saturation to 17 bits and optional mute.
module ip_sound_mixer
  import ip_sound_pkg::*;
#(
  parameter int unsigned PWM_DIV = 1,
  parameter int unsigned NUM_CH  = 4
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       sample_tick,
  input  logic signed [SAMPLE_W-1:0] ch0_in,
  input  logic signed [SAMPLE_W-1:0] ch1_in,
  input  logic signed [SAMPLE_W-1:0] ch2_in,
  input  logic signed [SAMPLE_W-1:0] ch3_in,
  input  logic        [VOL_W-1:0]    ch0_vol,
  input  logic        [VOL_W-1:0]    ch1_vol,
  input  logic        [VOL_W-1:0]    ch2_vol,
  input  logic        [VOL_W-1:0]    ch3_vol,
  input  logic                       mute,
  output logic signed [LEVEL_W-1:0]  signal_level,
  output logic                       level_valid,
  output logic                       overrun,
  output logic                       pwm_enable
);

  logic signed [SAMPLE_W-1:0] ch_in  [NUM_CH];
  logic        [VOL_W-1:0]    ch_vol [NUM_CH];

  assign ch_in[0]  = ch0_in;
  assign ch_in[1]  = ch1_in;
  assign ch_in[2]  = ch2_in;
  assign ch_in[3]  = ch3_in;
  assign ch_vol[0] = ch0_vol;
  assign ch_vol[1] = ch1_vol;
  assign ch_vol[2] = ch2_vol;
  assign ch_vol[3] = ch3_vol;

  mix_state_t                 state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [1:0]          idx_q, idx_d;
  logic signed [SAMPLE_W-1:0] samp_q [NUM_CH];
  logic signed [SAMPLE_W-1:0] samp_d [NUM_CH];
  logic        [VOL_W-1:0]    vol_q  [NUM_CH];
  logic        [VOL_W-1:0]    vol_d  [NUM_CH];
  logic signed [LEVEL_W-1:0]  level_q, level_d;
  logic                       valid_q, valid_d;
  logic                       ovr_q, ovr_d;

  logic signed [PROD_W-1:0]   prod;
  logic signed [SHIFT_W-1:0]  shifted;

  always_comb begin
    // Volume is zero-extended to 5 bits so 15 stays positive in the signed product.
    prod    = PROD_W'(samp_q[idx_q]) * PROD_W'($signed({1'b0, vol_q[idx_q]}));
    shifted = SHIFT_W'(acc_q >>> 2);

    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    samp_d  = samp_q;
    vol_d   = vol_q;
    level_d = level_q;
    valid_d = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            samp_d[i] = ch_in[i];
            vol_d[i]  = ch_vol[i];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + 2'd1;
        ovr_d = sample_tick;
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        level_d = mute ? '0 : sat_level(shifted);
        valid_d = 1'b1;
        ovr_d   = sample_tick;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        samp_q[i] <= '0;
        vol_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      samp_q  <= samp_d;
      vol_q   <= vol_d;
    end
  end

  assign signal_level = level_q;
  assign level_valid  = valid_q;
  assign overrun      = ovr_q;

  ip_pwm_enable_gen #(
    .PWM_DIV(PWM_DIV)
  ) u_pwm_enable_gen (
    .clk       (clk),
    .n_reset   (n_reset),
    .pwm_enable(pwm_enable)
  );

endmodule

// File: tb/tb_ip_sound_mixer.sv
// Directed bench for ip_sound_mixer: two instances (PWM_DIV=4 and PWM_DIV=1)
// share all inputs; expected values are hand-computed constants.
module tb_ip_sound_mixer;

  logic               clk = 1'b0;
  logic               n_reset;
  logic               sample_tick;
  logic               mute;
  logic signed [15:0] ch_in  [4];
  logic        [3:0]  ch_vol [4];

  logic signed [16:0] signal_level, signal_level_1;
  logic               level_valid, level_valid_1;
  logic               overrun, overrun_1;
  logic               pwm_enable, pwm_enable_1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  ip_sound_mixer #(.PWM_DIV(4)) dut (
    .clk(clk), .n_reset(n_reset), .sample_tick(sample_tick),
    .ch0_in(ch_in[0]), .ch1_in(ch_in[1]), .ch2_in(ch_in[2]), .ch3_in(ch_in[3]),
    .ch0_vol(ch_vol[0]), .ch1_vol(ch_vol[1]), .ch2_vol(ch_vol[2]), .ch3_vol(ch_vol[3]),
    .mute(mute), .signal_level(signal_level), .level_valid(level_valid),
    .overrun(overrun), .pwm_enable(pwm_enable)
  );

  ip_sound_mixer #(.PWM_DIV(1)) dut_div1 (
    .clk(clk), .n_reset(n_reset), .sample_tick(sample_tick),
    .ch0_in(ch_in[0]), .ch1_in(ch_in[1]), .ch2_in(ch_in[2]), .ch3_in(ch_in[3]),
    .ch0_vol(ch_vol[0]), .ch1_vol(ch_vol[1]), .ch2_vol(ch_vol[2]), .ch3_vol(ch_vol[3]),
    .mute(mute), .signal_level(signal_level_1), .level_valid(level_valid_1),
    .overrun(overrun_1), .pwm_enable(pwm_enable_1)
  );

  task automatic set_inputs(input int a, input int b, input int c, input int d, input int v);
    ch_in[0] = 16'(a);
    ch_in[1] = 16'(b);
    ch_in[2] = 16'(c);
    ch_in[3] = 16'(d);
    for (int i = 0; i < 4; i++) ch_vol[i] = 4'(v);
  endtask

  // Pulses sample_tick for edge k, then observes 8 negedges (after edges k..k+7).
  task automatic tick_and_watch(output int vcnt, output int vcyc, output int lvl, output int ocnt);
    vcnt = 0; vcyc = -1; lvl = 0; ocnt = 0;
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (level_valid) begin vcnt++; vcyc = j; lvl = int'(signal_level); end
      if (overrun) ocnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_reset = 1'b0; sample_tick = 1'b0; mute = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    #12;
    n_cmp++; if (signal_level !== 17'sd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", signal_level); end
    n_cmp++; if (level_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", level_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_cmp++; if (pwm_enable !== 1'b0) begin n_bad++; $display("FAIL reset_pwm4: got %b expected 0", pwm_enable); end
    n_cmp++; if (pwm_enable_1 !== 1'b0) begin n_bad++; $display("FAIL reset_pwm1: got %b expected 0", pwm_enable_1); end
  endtask

  task automatic test_divider;
    logic exp4;
    @(negedge clk) n_reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp4 = ((i % 4) == 3);
      n_cmp++; if (pwm_enable !== exp4) begin n_bad++; $display("FAIL div4_cycle%0d: got %b expected %b", i, pwm_enable, exp4); end
      n_cmp++; if (pwm_enable_1 !== 1'b1) begin n_bad++; $display("FAIL div1_cycle%0d: got %b expected 1", i, pwm_enable_1); end
    end
  endtask

  task automatic test_nominal;
    int vcnt, vcyc, lvl, ocnt;
    set_inputs(1000, 2000, -500, 0, 8);
    mute = 1'b0;
    tick_and_watch(vcnt, vcyc, lvl, ocnt);
    n_cmp++; if (vcnt != 1) begin n_bad++; $display("FAIL nominal_valid_count: got %0d expected 1", vcnt); end
    n_cmp++; if (vcyc != 5) begin n_bad++; $display("FAIL nominal_latency: got %0d expected 5", vcyc); end
    n_cmp++; if (lvl != 5000) begin n_bad++; $display("FAIL nominal_level: got %0d expected 5000", lvl); end
    n_cmp++; if (ocnt != 0) begin n_bad++; $display("FAIL nominal_overrun: got %0d expected 0", ocnt); end
    n_cmp++; if (signal_level_1 !== 17'sd5000) begin n_bad++; $display("FAIL nominal_level_div1: got %0d expected 5000", signal_level_1); end
  endtask

  task automatic test_saturation;
    int vcnt, vcyc, lvl, ocnt;
    set_inputs(32767, 32767, 32767, 32767, 15);
    tick_and_watch(vcnt, vcyc, lvl, ocnt);
    n_cmp++; if (lvl != 65535) begin n_bad++; $display("FAIL sat_pos: got %0d expected 65535", lvl); end
    n_cmp++; if (vcnt != 1) begin n_bad++; $display("FAIL sat_pos_valid: got %0d expected 1", vcnt); end
    set_inputs(-32768, -32768, -32768, -32768, 15);
    tick_and_watch(vcnt, vcyc, lvl, ocnt);
    n_cmp++; if (lvl != -65536) begin n_bad++; $display("FAIL sat_neg: got %0d expected -65536", lvl); end
    n_cmp++; if (signal_level !== 17'sh10000) begin n_bad++; $display("FAIL sat_neg_hold: got %0d expected -65536", signal_level); end
  endtask

  task automatic test_overrun;
    int vcnt, ocnt, ocyc, ocnt1, lvl5, lvl11;
    vcnt = 0; ocnt = 0; ocyc = -1; ocnt1 = 0; lvl5 = 0; lvl11 = 0;
    set_inputs(400, 400, 400, 400, 4);
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    for (int j = 0; j < 15; j++) begin
      if (level_valid) begin
        vcnt++;
        if (j == 5) lvl5 = int'(signal_level);
        if (j == 11) lvl11 = int'(signal_level);
      end
      if (overrun) begin ocnt++; ocyc = j; end
      if (overrun_1) ocnt1++;
      if (j == 2) begin
        sample_tick = 1'b1;
        set_inputs(100, 0, 0, 0, 4);
      end else if (j == 5) begin
        sample_tick = 1'b1;
      end else begin
        sample_tick = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++; if (vcnt != 2) begin n_bad++; $display("FAIL ovr_valid_count: got %0d expected 2", vcnt); end
    n_cmp++; if (lvl5 != 1600) begin n_bad++; $display("FAIL ovr_first_level: got %0d expected 1600", lvl5); end
    n_cmp++; if (lvl11 != 100) begin n_bad++; $display("FAIL ovr_second_level: got %0d expected 100", lvl11); end
    n_cmp++; if (ocnt != 1) begin n_bad++; $display("FAIL ovr_pulse_count: got %0d expected 1", ocnt); end
    n_cmp++; if (ocyc != 3) begin n_bad++; $display("FAIL ovr_pulse_cycle: got %0d expected 3", ocyc); end
    n_cmp++; if (ocnt1 != 1) begin n_bad++; $display("FAIL ovr_pulse_div1: got %0d expected 1", ocnt1); end
  endtask

  task automatic test_mute_hold;
    int vcnt, vcyc, lvl, ocnt, hold_bad;
    set_inputs(4000, 0, 0, 0, 15);
    mute = 1'b1;
    tick_and_watch(vcnt, vcyc, lvl, ocnt);
    n_cmp++; if (lvl != 0) begin n_bad++; $display("FAIL mute_level: got %0d expected 0", lvl); end
    n_cmp++; if (vcnt != 1) begin n_bad++; $display("FAIL mute_valid: got %0d expected 1", vcnt); end
    mute = 1'b0;
    vcnt = 0; lvl = 0; hold_bad = 0;
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    for (int j = 0; j < 13; j++) begin
      if (level_valid) begin vcnt++; lvl = int'(signal_level); end
      if (j > 5 && signal_level !== 17'sd15000) hold_bad++;
      if (j == 2) ch_in[0] = 16'sd1000;
      @(negedge clk);
    end
    n_cmp++; if (lvl != 15000) begin n_bad++; $display("FAIL unmute_level: got %0d expected 15000", lvl); end
    n_cmp++; if (vcnt != 1) begin n_bad++; $display("FAIL unmute_valid: got %0d expected 1", vcnt); end
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL level_hold: got %0d bad cycles expected 0", hold_bad); end
  endtask

  task automatic test_reset_midop;
    int vcnt, vcyc, lvl, ocnt;
    set_inputs(1000, 2000, -500, 0, 8);
    @(negedge clk) sample_tick = 1'b1;
    @(negedge clk) sample_tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    n_cmp++; if (signal_level !== 17'sd0) begin n_bad++; $display("FAIL midrst_level: got %0d expected 0", signal_level); end
    n_cmp++; if (pwm_enable_1 !== 1'b0) begin n_bad++; $display("FAIL midrst_pwm1: got %b expected 0", pwm_enable_1); end
    vcnt = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (level_valid) vcnt++;
    end
    n_reset = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (level_valid) vcnt++;
    end
    n_cmp++; if (vcnt != 0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d expected 0", vcnt); end
    set_inputs(-1000, -1000, -1000, -1000, 2);
    tick_and_watch(vcnt, vcyc, lvl, ocnt);
    n_cmp++; if (lvl != -2000) begin n_bad++; $display("FAIL postrst_level: got %0d expected -2000", lvl); end
    n_cmp++; if (vcyc != 5) begin n_bad++; $display("FAIL postrst_latency: got %0d expected 5", vcyc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_divider;
    test_nominal;
    test_saturation;
    test_overrun;
    test_mute_hold;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
